instr_fetch: RTL and testbench

Multicycle fetch stage: on a fetch request from the control unit it reads one 32-bit instruction word from instruction memory through a req/ready handshake. It latches the word into the instruction register (IR) and holds it stable across the decode, execute, memory and writeback cycles. It slices the IR into MIPS fields; `imm16` drives the sign-extension stage directly, and the register fields feed the register file.

---
 rtl/instr_fetch_pkg.sv | 27 ++
 rtl/instr_fetch.sv | 104 ++++++++++
 tb/tb_instr_fetch.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_pkg.sv
// rtl/instr_fetch_pkg.sv - shared fetch FSM encodings, MIPS field positions and NOP constant
package instr_fetch_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int OPC_HI   = 31;
    localparam int OPC_LO   = 26;
    localparam int RS_HI    = 25;
    localparam int RS_LO    = 21;
    localparam int RT_HI    = 20;
    localparam int RT_LO    = 16;
    localparam int RD_HI    = 15;
    localparam int RD_LO    = 11;
    localparam int SHAMT_HI = 10;
    localparam int SHAMT_LO = 6;
    localparam int FUNCT_HI = 5;
    localparam int FUNCT_LO = 0;
    localparam int IMM_HI   = 15;
    localparam int IMM_LO   = 0;
    localparam int JT_HI    = 25;
    localparam int JT_LO    = 0;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - multicycle fetch stage with IR and field slicer; FETCH_ALIGN_CHECK_EN enables misalignment fault
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_IR = NOP_INSTR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_start,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        busy,
    output logic        fetch_done,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jtarget,
    output logic [31:0] fetch_count,
    output logic        fault
);

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_ir;
    logic [31:0] r_fetch_count;
    logic        w_accept;

`ifdef FETCH_ALIGN_CHECK_EN
    logic        r_fault;
    logic        w_misaligned;

    assign w_misaligned = (pc_in[1:0] != 2'b00);
    assign w_accept     = fetch_start && !w_misaligned;
`else
    assign w_accept     = fetch_start;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_addr        <= 32'h0000_0000;
            r_ir          <= RESET_IR;
            r_fetch_count <= 32'h0000_0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        // Without the alignment check the low address bits are dropped here
                        r_addr  <= pc_in & 32'hFFFF_FFFC;
                        r_state <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ready) begin
                        r_ir          <= mem_rdata;
                        r_fetch_count <= r_fetch_count + 32'd1;
                        r_state       <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (r_state == ST_IDLE) && fetch_start && w_misaligned;
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign mem_req     = (r_state == ST_REQ);
    assign busy        = (r_state != ST_IDLE);
    assign fetch_done  = (r_state == ST_DONE);
    assign mem_addr    = r_addr;
    assign fetch_count = r_fetch_count;

    assign instr   = r_ir;
    assign opcode  = r_ir[OPC_HI:OPC_LO];
    assign rs      = r_ir[RS_HI:RS_LO];
    assign rt      = r_ir[RT_HI:RT_LO];
    assign rd      = r_ir[RD_HI:RD_LO];
    assign shamt   = r_ir[SHAMT_HI:SHAMT_LO];
    assign funct   = r_ir[FUNCT_HI:FUNCT_LO];
    assign imm16   = r_ir[IMM_HI:IMM_LO];
    assign jtarget = r_ir[JT_HI:JT_LO];

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch against a transaction-level model
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_start;
    logic [31:0] pc_in;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        busy;
    logic        fetch_done;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] jtarget;
    logic [31:0] fetch_count;
    logic        fault;

    int total = 0;
    int bad   = 0;

    instr_fetch dut (
        .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready), .busy(busy), .fetch_done(fetch_done),
        .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16), .jtarget(jtarget),
        .fetch_count(fetch_count), .fault(fault)
    );

    always #5 clk = ~clk;

`ifdef FETCH_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    // Model: an outstanding fetch, a completion in its report cycle, and the architectural IR/count.
    bit          m_pending;
    bit          m_done;
    bit          m_fault;
    logic [31:0] m_addr;
    logic [31:0] m_ir;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic rst, input logic fs, input logic [31:0] pc,
                              input logic rdy, input logic [31:0] rdata);
        if (rst) begin
            m_pending = 0; m_done = 0; m_fault = 0;
            m_addr = 32'h0; m_ir = 32'h0; m_count = 32'h0;
        end else begin
            m_fault = 0;
            if (m_done) begin
                m_done = 0;
            end else if (m_pending) begin
                if (rdy) begin
                    m_ir = rdata;
                    m_count = m_count + 1;
                    m_pending = 0;
                    m_done = 1;
                end
            end else if (fs) begin
                if (ALIGN_EN && pc[1:0] != 2'b00) begin
                    m_fault = 1;
                end else begin
                    m_pending = 1;
                    m_addr = {pc[31:2], 2'b00};
                end
            end
        end
    endtask

    task automatic compare();
        chk("mem_req", {31'd0, mem_req}, {31'd0, m_pending});
        chk("busy", {31'd0, busy}, {31'd0, m_pending | m_done});
        chk("fetch_done", {31'd0, fetch_done}, {31'd0, m_done});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("instr", instr, m_ir);
        chk("opcode", {26'd0, opcode}, {26'd0, m_ir[31:26]});
        chk("rs", {27'd0, rs}, {27'd0, m_ir[25:21]});
        chk("rt", {27'd0, rt}, {27'd0, m_ir[20:16]});
        chk("rd", {27'd0, rd}, {27'd0, m_ir[15:11]});
        chk("shamt", {27'd0, shamt}, {27'd0, m_ir[10:6]});
        chk("funct", {26'd0, funct}, {26'd0, m_ir[5:0]});
        chk("imm16", {16'd0, imm16}, {16'd0, m_ir[15:0]});
        chk("jtarget", {6'd0, jtarget}, {6'd0, m_ir[25:0]});
        chk("fetch_count", fetch_count, m_count);
        if (m_pending) chk("mem_addr", mem_addr, m_addr);
    endtask

    task automatic cycle(input logic rst, input logic fs, input logic [31:0] pc,
                         input logic rdy, input logic [31:0] rdata);
        reset = rst; fetch_start = fs; pc_in = pc; mem_ready = rdy; mem_rdata = rdata;
        @(posedge clk);
        model_step(rst, fs, pc, rdy, rdata);
        @(negedge clk);
        compare();
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        int          lat;
        logic [31:0] saved_ir;
        logic [31:0] saved_cnt;
        logic [31:0] r_pc;
        logic [31:0] r_lo;
        logic [31:0] r_data;

        reset = 1'b1; fetch_start = 1'b0; pc_in = '0; mem_ready = 1'b0; mem_rdata = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (3) idle();
        chk("rst_instr", instr, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);

        // Zero-wait fetch
        cycle(1'b0, 1'b1, 32'h0000_0040, 1'b0, 32'h0);
        chk("f1_addr", mem_addr, 32'h0000_0040);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h2108_FFFC);
        lat = 2;
        chk("f1_done_lat2", {31'd0, fetch_done}, 32'd1);
        chk("f1_opcode", {26'd0, opcode}, 32'h08);
        chk("f1_rs", {27'd0, rs}, 32'd8);
        chk("f1_rt", {27'd0, rt}, 32'd8);
        chk("f1_imm16", {16'd0, imm16}, 32'h0000_FFFC);
        chk("f1_count", fetch_count, 32'd1);
        idle();

        // Three wait cycles with an ignored start during the wait
        cycle(1'b0, 1'b1, 32'h0000_1000, 1'b0, 32'h0);
        lat = 1;
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, (i == 1), 32'h0000_2000, 1'b0, 32'hFFFF_FFFF);
            lat++;
            chk("f2_busy", {31'd0, busy}, 32'd1);
            chk("f2_addr_stable", mem_addr, 32'h0000_1000);
        end
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h0123_4567);
        lat++;
        while (!fetch_done && lat < 12) begin
            idle();
            lat++;
        end
        chk("f2_latency", lat, 32'd5);
        chk("f2_instr", instr, 32'h0123_4567);
        idle();
        chk("f2_count_once", fetch_count, 32'd2);
        chk("f2_idle", {31'd0, busy}, 32'd0);

        // Reset coincident with mem_ready in REQ
        cycle(1'b0, 1'b1, 32'h0000_0080, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF);
        chk("rm_instr", instr, 32'h0);
        chk("rm_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rm_count", fetch_count, 32'd0);
        idle();

        // Counter wrap from all-ones
        m_count = 32'hFFFF_FFFF;
        force dut.r_fetch_count = 32'hFFFF_FFFF;
        idle();
        release dut.r_fetch_count;
        idle();
        cycle(1'b0, 1'b1, 32'h0000_0100, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'hAAAA_5555);
        chk("wrap_count", fetch_count, 32'h0);
        idle();

        // Misaligned start
        saved_ir  = instr;
        saved_cnt = fetch_count;
        cycle(1'b0, 1'b1, 32'h0000_0042, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
        chk("al_fault", {31'd0, fault}, 32'd1);
        chk("al_no_req", {31'd0, mem_req}, 32'd0);
        idle();
        chk("al_fault_pulse", {31'd0, fault}, 32'd0);
        chk("al_ir_kept", instr, saved_ir);
        chk("al_count_kept", fetch_count, saved_cnt);
`else
        chk("al_addr_forced", mem_addr, 32'h0000_0040);
        chk("al_fault_tied", {31'd0, fault}, 32'd0);
        cycle(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_0000);
        idle();
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r_pc = $urandom;
            r_lo = $urandom_range(0, 3);
            r_data = $urandom;
            if (r_lo != 0) r_pc[1:0] = 2'b00;
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) == 0), r_pc,
                  ($urandom_range(0, 1) == 0), r_data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
